// File: rtl/note_recorder.sv
// rtl/note_recorder.sv - debounced free-play note capture into a playback buffer
module note_recorder #(
    parameter int DEPTH    = 1024,
    parameter int MIN_HOLD = 2_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rec_en,
    input  logic        clear,
    input  logic [31:0] key_fre,
    input  logic [13:0] rd_addr,
    output logic [31:0] rd_fre,
    output logic [13:0] rec_len,
    output logic        full,
    output logic        overflow,
    output logic        busy
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(MIN_HOLD + 1);
    localparam logic [CW-1:0] HOLD_MAX = CW'(MIN_HOLD);
    localparam logic [14:0]   DEPTH_W  = 15'(DEPTH);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t         state;
    logic [31:0]    held_fre;
    logic [CW-1:0]  hold_cnt;
    logic [31:0]    mem [DEPTH];
    logic           key_changed;
    logic           qualifies;
    logic           wr_en;

    assign full        = ({1'b0, rec_len} == DEPTH_W);
    assign key_changed = (key_fre != held_fre);
    // A note is judged only when the tracked value stops being sampled.
    assign qualifies   = (state == HOLD) && rec_en && !clear && key_changed
                         && (hold_cnt == HOLD_MAX);
    assign wr_en       = qualifies && !full;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[rec_len[AW-1:0]] <= held_fre;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            held_fre <= '0;
            hold_cnt <= '0;
            rec_len  <= '0;
            overflow <= 1'b0;
            busy     <= 1'b0;
            rd_fre   <= '0;
        end else begin
            // Uses the pre-edge rec_len, so a same-cycle write reads back as 0.
            rd_fre <= (rd_addr < rec_len) ? mem[rd_addr[AW-1:0]] : 32'd0;
            if (clear) begin
                state    <= IDLE;
                busy     <= 1'b0;
                hold_cnt <= '0;
                rec_len  <= '0;
                overflow <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (rec_en && key_fre != 32'd0) begin
                            held_fre <= key_fre;
                            hold_cnt <= CW'(1);
                            state    <= HOLD;
                            busy     <= 1'b1;
                        end
                    end
                    HOLD: begin
                        if (!rec_en) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else if (!key_changed) begin
                            if (hold_cnt != HOLD_MAX) begin
                                hold_cnt <= hold_cnt + CW'(1);
                            end
                        end else begin
                            if (wr_en) begin
                                rec_len <= rec_len + 14'd1;
                            end else if (qualifies) begin
                                overflow <= 1'b1;
                            end
                            if (key_fre != 32'd0) begin
                                held_fre <= key_fre;
                                hold_cnt <= CW'(1);
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_note_recorder.sv
// tb/tb_note_recorder.sv - directed bench for note_recorder with MIN_HOLD=4, DEPTH=4
module tb_note_recorder;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rec_en = 1'b0;
    logic        clear = 1'b0;
    logic [31:0] key_fre = '0;
    logic [13:0] rd_addr = '0;
    logic [31:0] rd_fre;
    logic [13:0] rec_len;
    logic        full;
    logic        overflow;
    logic        busy;

    int total = 0;
    int bad = 0;

    note_recorder #(.DEPTH(4), .MIN_HOLD(4)) dut (
        .clk(clk), .reset(reset), .rec_en(rec_en), .clear(clear),
        .key_fre(key_fre), .rd_addr(rd_addr), .rd_fre(rd_fre),
        .rec_len(rec_len), .full(full), .overflow(overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic note(input logic [31:0] f, input int n);
        key_fre = f;
        repeat (n) step();
        key_fre = '0;
        step();
    endtask

    initial begin
        #12;
        chk("reset_rec_len", 32'(rec_len), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_rd_fre", rd_fre, 0);
        reset = 1'b1;
        rec_en = 1'b1;
        step();

        // 1: minimum-length note then read back
        key_fre = 262;
        step();
        chk("s1_busy_entry", 32'(busy), 1);
        repeat (3) step();
        chk("s1_len_before_release", 32'(rec_len), 0);
        key_fre = 0;
        step();
        chk("s1_len_release", 32'(rec_len), 1);
        chk("s1_busy_release", 32'(busy), 0);
        rd_addr = 0;
        step();
        chk("s1_rd0", rd_fre, 262);
        rd_addr = 1;
        step();
        chk("s1_rd1_beyond", rd_fre, 0);

        // 2: glitch too short to record
        clear = 1'b1;
        step();
        clear = 1'b0;
        key_fre = 294;
        repeat (3) step();
        chk("s2_busy_hold", 32'(busy), 1);
        key_fre = 0;
        step();
        chk("s2_len", 32'(rec_len), 0);
        chk("s2_busy_drop", 32'(busy), 0);

        // 3: direct change between two notes
        key_fre = 330;
        repeat (5) step();
        key_fre = 349;
        step();
        chk("s3_len_first", 32'(rec_len), 1);
        chk("s3_busy_change", 32'(busy), 1);
        repeat (3) step();
        key_fre = 0;
        step();
        chk("s3_len", 32'(rec_len), 2);
        rd_addr = 0;
        step();
        chk("s3_rd0", rd_fre, 330);
        rd_addr = 1;
        step();
        chk("s3_rd1", rd_fre, 349);

        // 4: fill, overflow, clear
        clear = 1'b1;
        step();
        clear = 1'b0;
        for (int i = 0; i < 3; i++) note(100 + i, 4);
        chk("s4_full_3", 32'(full), 0);
        note(103, 4);
        chk("s4_full_4", 32'(full), 1);
        chk("s4_ovf_4", 32'(overflow), 0);
        note(104, 4);
        chk("s4_ovf_5", 32'(overflow), 1);
        chk("s4_len_5", 32'(rec_len), 4);
        rd_addr = 3;
        step();
        chk("s4_rd3", rd_fre, 103);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("s4_clr_len", 32'(rec_len), 0);
        chk("s4_clr_ovf", 32'(overflow), 0);
        chk("s4_clr_full", 32'(full), 0);

        // 5a: clear on the qualifying release edge
        key_fre = 500;
        repeat (4) step();
        key_fre = 0;
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("s5_clr_commit_len", 32'(rec_len), 0);
        chk("s5_clr_commit_busy", 32'(busy), 0);
        rd_addr = 0;
        step();
        chk("s5_rd0_empty", rd_fre, 0);

        // 5b: rec_en dropped mid-hold
        key_fre = 600;
        repeat (6) step();
        chk("s5_busy_hold", 32'(busy), 1);
        rec_en = 1'b0;
        step();
        chk("s5_recen_busy", 32'(busy), 0);
        chk("s5_recen_len", 32'(rec_len), 0);
        key_fre = 0;
        step();
        chk("s5_after_len", 32'(rec_len), 0);
        rec_en = 1'b1;

        // 6: async reset mid-note
        note(700, 4);
        note(701, 4);
        rd_addr = 0;
        key_fre = 800;
        repeat (2) step();
        chk("s6_pre_len", 32'(rec_len), 2);
        chk("s6_pre_busy", 32'(busy), 1);
        chk("s6_pre_rd", rd_fre, 700);
        #2;
        reset = 1'b0;
        #1;
        chk("s6_rst_len", 32'(rec_len), 0);
        chk("s6_rst_busy", 32'(busy), 0);
        chk("s6_rst_rd", rd_fre, 0);
        #1;
        reset = 1'b1;
        key_fre = 0;
        step();
        note(900, 4);
        chk("s6_new_len", 32'(rec_len), 1);
        step();
        chk("s6_new_rd0", rd_fre, 900);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
